md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI and LO registers.
- Produces XALUOUT, the HI/LO read value consumed by the write-back data select as its fourth source.
- Drives busy, which the hazard unit uses to stall later multiply/divide/mfhi/mflo instructions.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1-15)
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1-15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous reset, active-low; state is cleared at a rising clk edge while reset==0
- start  input  1  launch the operation given by md_op (one-cycle pulse from EX)
- md_op  input  2  0=mult, 1=multu, 2=div, 3=divu
- A  input  32  operand rs (after forwarding)
- B  input  32  operand rt (after forwarding)
- mthi  input  1  write A into HI
- mtlo  input  1  write A into LO
- hilo_sel  input  1  read select: 1=HI, 0=LO
- busy  output  1  operation in flight
- XALUOUT  output  32  hilo_sel ? HI : LO, combinational from the registers

Behaviour:
- Reset (reset==0 at an edge):
  - HI=0, LO=0, busy=0, counter=0, state=IDLE.
  - XALUOUT therefore reads 0.
  - Reset asserted mid-operation aborts the operation. No HI/LO commit occurs.
- States: IDLE, RUN.
- IDLE, start=1 sampled at edge T:
  - Latch md_op, A and B.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from cycle T+1.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter reaches 0, HI/LO are written atomically and state returns to IDLE.
  - For start at edge T and latency N: busy=1 in cycles T+1 through T+N; new HI/LO and busy=0 are visible from cycle T+N+1.
- Inputs ignored in RUN: start, mthi and mtlo. The hazard unit guarantees they are not issued; if they arrive anyway, the block must stay unaffected.
- mthi/mtlo in IDLE: HI (resp. LO) takes A at that edge, with no busy.
  - start has priority over mthi/mtlo in the same cycle; the move is dropped.
  - mthi and mtlo together write both registers.
- mult: signed 32x32 -> 64. HI=product[63:32], LO=product[31:0].
- multu: same as mult, unsigned.
- div: signed. LO=quotient truncated toward zero; HI=remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned. LO=quotient, HI=remainder.
- Divide by zero (B==0 for div/divu):
  - Full DIV_CYCLES busy period still occurs.
  - At completion HI and LO keep their prior values.
- Operands are taken only from the start-cycle latch. Changes on A/B during RUN have no effect.
- Result computation may be combinational from the latched operands or iterative. Only the commit timing above is observable.
- XALUOUT always reflects the current register contents.
  - During RUN it shows the old HI/LO.
  - No internal bypass of a same-cycle mthi/mtlo write.

Test Plan:
- Reset, then hilo_sel=0/1 -> XALUOUT=0x00000000 both, busy=0. Hold reset low 3 cycles -> unchanged.
- start, md_op=0, A=0xFFFFFFFF, B=2 -> busy=1 exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat with md_op=1 -> HI=0x00000001, LO=0xFFFFFFFE.
- start, md_op=2, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - md_op=3, A=7, B=2 -> LO=3, HI=1.
  - md_op=2, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x1234 then mtlo A=0x5678 -> HI=0x1234, LO=0x5678.
  - Then divu A=7, B=0 -> busy 10 cycles, HI/LO still 0x1234/0x5678.
- multu A=3, B=4 started; in cycle 2 of RUN pulse start (md_op=3) and mtlo (A=0xDEAD) -> both ignored, result HI=0, LO=12 after 5 cycles.
  - A/B changed mid-run -> no effect.
- div started with HI=LO=0x11; reset low at cycle 4 of RUN -> next cycle busy=0, HI=LO=0, no later commit.
  - start and mthi in same IDLE cycle -> only the operation executes.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] XALUOUT
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        load;
    logic        commit;
    logic        write_hi;
    logic        write_lo;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        divisor;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start wins over a same-cycle move; everything except the counter is frozen in RUN
    always_comb begin
        state_next = state;
        load       = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    write_hi = mthi;
                    write_lo = mtlo;
                end
            end
            RUN: begin
                if (count <= 4'd1) begin
                    commit     = res_valid;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case entirely
    assign a_neg   = (op_q == OP_DIV) && a_q[31];
    assign b_neg   = (op_q == OP_DIV) && b_q[31];
    assign mag_a   = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b   = b_neg ? (32'd0 - b_q) : b_q;
    assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b1;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = rem;
                res_lo    = quot;
                res_valid = (b_q != 32'd0);
            end
            default: res_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 4'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            if (load) begin
                op_q  <= md_op;
                a_q   <= A;
                b_q   <= B;
                count <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (state == RUN) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (write_hi) begin
                    hi <= A;
                end
                if (write_lo) begin
                    lo <= A;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    assign XALUOUT = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against an arithmetic model
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] XALUOUT;

    int tests;
    int fails;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A(A),
        .B(B),
        .mthi(mthi),
        .mtlo(mtlo),
        .hilo_sel(hilo_sel),
        .busy(busy),
        .XALUOUT(XALUOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            2'd0: begin
                sp   = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            2'd1: begin
                up   = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            2'd2: begin
                if (b != 32'd0) begin
                    sq   = sa / sb;
                    sr   = sa % sb;
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
            end
            default: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hilo_sel = 1'b1;
        #1 hi = XALUOUT;
        hilo_sel = 1'b0;
        #1 lo = XALUOUT;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        int          cycles;
        logic [31:0] hi, lo;
        run_op(op, a, b, cycles);
        model_apply(op, a, b);
        read_hilo(hi, lo);
        tests++;
        if (cycles !== (op[1] ? DIV_N : MULT_N)) begin
            fails++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cycles, op[1] ? DIV_N : MULT_N);
        end
        tests++;
        if (hi !== m_hi || lo !== m_lo) begin
            fails++;
            $display("FAIL %s op=%0d a=%h b=%h hi/lo got=%h/%h exp=%h/%h",
                     name, op, a, b, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            read_hilo(hi, lo);
            tests++;
            if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset cyc=%0d hi/lo/busy got=%h/%h/%b exp=0/0/0", i, hi, lo, busy);
            end
        end
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult;
        check_op("mult_neg1x2", 2'd0, 32'hFFFFFFFF, 32'd2);
        check_op("multu_maxx2", 2'd1, 32'hFFFFFFFF, 32'd2);
    endtask

    task automatic test_div;
        check_op("div_neg7_2", 2'd2, 32'hFFFFFFF9, 32'd2);
        check_op("divu_7_2", 2'd3, 32'd7, 32'd2);
        check_op("div_overflow", 2'd2, 32'h80000000, 32'hFFFFFFFF);
        check_op("div_7_neg2", 2'd2, 32'd7, 32'hFFFFFFFE);
    endtask

    task automatic test_moves;
        logic [31:0] hi, lo;
        @(negedge clk);
        mthi = 1'b1;
        A    = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b1;
        A    = 32'h5678;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL move_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        mtlo = 1'b0;
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        read_hilo(hi, lo);
        tests++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            fails++;
            $display("FAIL moves hi/lo got=%h/%h exp=00001234/00005678", hi, lo);
        end
        check_op("divu_by_zero", 2'd3, 32'd7, 32'd0);
        check_op("div_by_zero", 2'd2, 32'hFFFFFFF0, 32'd0);
    endtask

    task automatic test_ignore_in_run;
        int          cycles;
        logic [31:0] hi, lo;
        @(negedge clk);
        start = 1'b1;
        md_op = 2'd1;
        A     = 32'd3;
        B     = 32'd4;
        @(negedge clk);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (cycles == 2) begin
                start = 1'b1;
                md_op = 2'd3;
                mtlo  = 1'b1;
                A     = 32'hDEAD;
                B     = 32'd0;
            end else begin
                start = 1'b0;
                mtlo  = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mtlo  = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd12;
        read_hilo(hi, lo);
        tests++;
        if (cycles !== MULT_N) begin
            fails++;
            $display("FAIL ignore_busy_cycles got=%0d exp=%0d", cycles, MULT_N);
        end
        tests++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            fails++;
            $display("FAIL ignore_result hi/lo got=%h/%h exp=00000000/0000000c", hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] hi, lo;
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        A    = 32'h11;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        read_hilo(hi, lo);
        tests++;
        if (hi !== 32'h11 || lo !== 32'h11) begin
            fails++;
            $display("FAIL both_moves hi/lo got=%h/%h exp=00000011/00000011", hi, lo);
        end
        start = 1'b1;
        md_op = 2'd2;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_hilo(hi, lo);
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL abort busy/hi/lo got=%b/%h/%h exp=0/0/0", busy, hi, lo);
        end
        reset = 1'b1;
        repeat (12) @(negedge clk);
        read_hilo(hi, lo);
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL abort_late busy/hi/lo got=%b/%h/%h exp=0/0/0", busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_start_priority;
        int          cycles;
        logic [31:0] hi, lo;
        @(negedge clk);
        start = 1'b1;
        mthi  = 1'b1;
        md_op = 2'd3;
        A     = 32'h55;
        B     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        read_hilo(hi, lo);
        tests++;
        if (cycles !== DIV_N || hi !== m_hi || lo !== m_lo) begin
            fails++;
            $display("FAIL start_priority cycles/hi/lo got=%0d/%h/%h exp=%0d/%h/%h",
                     cycles, hi, lo, DIV_N, m_hi, m_lo);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b, v;
        logic [31:0] hi, lo;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            check_op("random", op, a, b);
            if ($urandom_range(0, 2) == 0) begin
                v = $urandom;
                @(negedge clk);
                mthi = 1'b1;
                A    = v;
                @(negedge clk);
                mthi = 1'b0;
                m_hi = v;
                read_hilo(hi, lo);
                tests++;
                if (hi !== m_hi || lo !== m_lo) begin
                    fails++;
                    $display("FAIL random_mthi hi/lo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 2'd0;
        A        = 32'd0;
        B        = 32'd0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        hilo_sel = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_moves;
        test_ignore_in_run;
        test_reset_abort;
        test_start_priority;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
